button_event_ctrl: RTL and testbench

- Gesture controller that sits directly behind the push-button debouncer.
- Consumes the debouncer's clean level (STATE) and its one-cycle DOWN/UP pulses.
- Classifies each interaction as a short press, long press, double click or auto-repeat, and emits one registered single-cycle pulse per event.
- Pulses feed the user-interface sequencer (menu stepping, mode select) so that no downstream block does its own timing.

---
 rtl/button_event_ctrl_if.sv | 28 ++
 rtl/button_event_ctrl.sv | 164 ++++++++++++++++
 tb/tb_button_event_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_if.sv
// Gesture controller bundle: debouncer inputs plus gesture event outputs.
// Latency: none (wires only); the controller registers every output.
// Backpressure: none; events are fire-and-forget single-cycle pulses.
//
// master : debouncer / sequencer side (drives enable and button signals)
// slave  : button_event_ctrl side (drives event pulses, busy, fsm_state)
interface button_event_ctrl_if;
    logic       enable;
    logic       button_state;
    logic       button_down;
    logic       button_up;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic       repeat_pulse;
    logic       busy;
    logic [2:0] fsm_state;

    modport master (
        output enable, button_state, button_down, button_up,
        input  short_press, long_press, double_click, repeat_pulse, busy, fsm_state
    );

    modport slave (
        input  enable, button_state, button_down, button_up,
        output short_press, long_press, double_click, repeat_pulse, busy, fsm_state
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Classifies debounced button activity into short/long/double-click/repeat pulses.
// Latency: events are registered, high one cycle on the edge the gesture resolves.
// Backpressure: none; downstream must accept each single-cycle pulse.
//
// Ports: clk, rst_n (async active-low), bus (slave modport of button_event_ctrl_if):
//   in  enable, button_state, button_down, button_up
//   out short_press, long_press, double_click, repeat_pulse, busy, fsm_state
module button_event_ctrl #(
    parameter int TICK_DIV     = 20000,
    parameter int LONG_TICKS   = 800,
    parameter int DCLICK_TICKS = 250,
    parameter int REPEAT_TICKS = 150
) (
    input  logic                clk,
    input  logic                rst_n,
    button_event_ctrl_if.slave  bus
);

    localparam int MAX_LD    = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int MAX_TICKS = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int PRESC_W   = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESSED = 3'd1,
        WAIT2   = 3'd2,
        SECOND  = 3'd3,
        HELD    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   tick_cnt;
    logic               short_q;
    logic               long_q;
    logic               dbl_q;
    logic               rep_q;

    logic tick;
    logic down_ev;
    logic up_ev;
    logic hit_long;
    logic hit_dclick;
    logic hit_repeat;

    assign tick = (presc == PRESC_W'(TICK_DIV - 1));

    // A DOWN and UP in the same cycle cancel each other out.
    assign down_ev = bus.button_down & ~bus.button_up;
    assign up_ev   = bus.button_up   & ~bus.button_down;

    // A threshold is reached on the tick that would bring the count to N.
    // ">=" keeps firing possible after a held-off threshold (count saturates).
    assign hit_long   = tick && (tick_cnt >= CNT_W'(LONG_TICKS - 1));
    assign hit_dclick = tick && (tick_cnt >= CNT_W'(DCLICK_TICKS - 1));
    assign hit_repeat = tick && (tick_cnt >= CNT_W'(REPEAT_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            tick_cnt <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            dbl_q    <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            rep_q   <= 1'b0;

            // Free-running timebase; every transition below overrides it with a
            // clear so the next state's timing starts from exactly zero.
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && (tick_cnt != '1))
                tick_cnt <= tick_cnt + 1'b1;

            if (!bus.enable) begin
                state    <= IDLE;
                presc    <= '0;
                tick_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        presc    <= '0;
                        tick_cnt <= '0;
                        if (down_ev)
                            state <= PRESSED;
                        else if (bus.button_state && !bus.button_down && !bus.button_up)
                            // Button already down with no press edge seen.
                            state <= LOCKOUT;
                    end
                    PRESSED: begin
                        if (up_ev) begin
                            state    <= WAIT2;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end else if (hit_long) begin
                            long_q   <= 1'b1;
                            state    <= HELD;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end
                    end
                    HELD: begin
                        if (up_ev) begin
                            state    <= IDLE;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end else if (hit_repeat) begin
                            // Restart the interval so repeats stay periodic.
                            rep_q    <= 1'b1;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end
                    end
                    WAIT2: begin
                        if (down_ev) begin
                            state    <= SECOND;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end else if (hit_dclick) begin
                            short_q  <= 1'b1;
                            state    <= IDLE;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end
                    end
                    SECOND: begin
                        if (up_ev) begin
                            dbl_q    <= 1'b1;
                            state    <= IDLE;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end
                    end
                    LOCKOUT: begin
                        if (!bus.button_state) begin
                            state    <= IDLE;
                            presc    <= '0;
                            tick_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        presc    <= '0;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_click = dbl_q;
    assign bus.repeat_pulse = rep_q;
    assign bus.busy         = (state != IDLE);
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with small timing parameters.
// Latency: pulse cycles are logged at the falling edge and compared to hand-computed edges.
// Backpressure: not applicable.
module tb_button_event_ctrl;

    localparam int EV_SHORT = 0;
    localparam int EV_LONG  = 1;
    localparam int EV_DBL   = 2;
    localparam int EV_REP   = 3;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    button_event_ctrl_if bus();

    button_event_ctrl #(
        .TICK_DIV    (4),
        .LONG_TICKS  (10),
        .DCLICK_TICKS(5),
        .REPEAT_TICKS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event logger: counts and first/second cycle of each pulse type.
    int         cnt    [4];
    int         first  [4];
    int         second [4];
    int         multi;
    int         busy_fall;
    logic       prev_busy;
    logic [3:0] ev;

    always @(negedge clk) begin
        ev = {bus.repeat_pulse, bus.double_click, bus.long_press, bus.short_press};
        if ($countones(ev) > 1) multi++;
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
                if (cnt[i] == 0) first[i] = cyc;
                else if (cnt[i] == 1) second[i] = cyc;
                cnt[i]++;
            end
        end
        if (prev_busy && !bus.busy) busy_fall = cyc;
        prev_busy = bus.busy;
    end

    task automatic clear_log();
        for (int i = 0; i < 4; i++) begin
            cnt[i]    = 0;
            first[i]  = -1;
            second[i] = -1;
        end
        busy_fall = -1;
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(output int edge_idx);
        bus.button_down  = 1'b1;
        bus.button_state = 1'b1;
        step(1);
        edge_idx = cyc;
        bus.button_down = 1'b0;
    endtask

    task automatic release_btn(output int edge_idx);
        bus.button_up    = 1'b1;
        bus.button_state = 1'b0;
        step(1);
        edge_idx = cyc;
        bus.button_up = 1'b0;
    endtask

    int e0;
    int e1;
    int e2;
    int eu;

    initial begin
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        multi     = 0;
        prev_busy = 1'b0;
        clear_log();
        rst_n            = 1'b0;
        bus.enable       = 1'b1;
        bus.button_state = 1'b0;
        bus.button_down  = 1'b0;
        bus.button_up    = 1'b0;

        // Reset state
        step(3);
        check_val("rst_fsm", int'(bus.fsm_state), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_events", int'({bus.short_press, bus.long_press, bus.double_click, bus.repeat_pulse}), 0);
        rst_n = 1'b1;
        step(2);

        // Short press: UP 20 clocks after DOWN, SHORT 20 clocks after UP
        clear_log();
        press(e0);
        check_val("short_pressed_state", int'(bus.fsm_state), 1);
        step(19);
        release_btn(eu);
        check_val("short_wait2_state", int'(bus.fsm_state), 2);
        step(25);
        check_val("short_cnt", cnt[EV_SHORT], 1);
        check_val("short_cycle", first[EV_SHORT], e0 + 40);
        check_val("short_busy_fall", busy_fall, e0 + 40);
        check_val("short_others", cnt[EV_LONG] + cnt[EV_DBL] + cnt[EV_REP], 0);

        // Long press with repeat
        clear_log();
        press(e0);
        step(45);
        check_val("long_held_state", int'(bus.fsm_state), 4);
        step(24);
        release_btn(eu);
        check_val("long_up_idle", int'(bus.fsm_state), 0);
        step(20);
        check_val("long_cnt", cnt[EV_LONG], 1);
        check_val("long_cycle", first[EV_LONG], e0 + 40);
        check_val("rep_cnt", cnt[EV_REP], 2);
        check_val("rep_first", first[EV_REP], e0 + 52);
        check_val("rep_second", second[EV_REP], e0 + 64);
        check_val("long_no_short_dbl", cnt[EV_SHORT] + cnt[EV_DBL], 0);

        // Double click
        clear_log();
        press(e0);
        step(7);
        release_btn(e1);
        step(11);
        press(e2);
        check_val("dbl_second_state", int'(bus.fsm_state), 3);
        step(99);
        release_btn(eu);
        step(30);
        check_val("dbl_cnt", cnt[EV_DBL], 1);
        check_val("dbl_cycle", first[EV_DBL], e0 + 120);
        check_val("dbl_no_short_long", cnt[EV_SHORT] + cnt[EV_LONG], 0);

        // Boundary races
        clear_log();
        press(e0);
        step(39);
        release_btn(eu);
        check_val("race_up_state", int'(bus.fsm_state), 2);
        step(19);
        press(e1);
        check_val("race_down_state", int'(bus.fsm_state), 3);
        step(5);
        release_btn(e2);
        step(30);
        check_val("race_no_long", cnt[EV_LONG], 0);
        check_val("race_no_short", cnt[EV_SHORT], 0);
        check_val("race_dbl", cnt[EV_DBL], 1);

        // Lockout: button held through reset release
        clear_log();
        rst_n            = 1'b0;
        bus.button_state = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(5);
        check_val("lock_state", int'(bus.fsm_state), 5);
        check_val("lock_busy", int'(bus.busy), 1);
        press(e0);
        step(60);
        check_val("lock_down_ignored", int'(bus.fsm_state), 5);
        release_btn(eu);
        step(3);
        check_val("lock_exit_state", int'(bus.fsm_state), 0);
        check_val("lock_no_events", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        press(e0);
        step(3);
        release_btn(eu);
        step(25);
        check_val("lock_then_short_cnt", cnt[EV_SHORT], 1);
        check_val("lock_then_short_cycle", first[EV_SHORT], eu + 20);

        // Abort: ENABLE dropped mid-WAIT2
        clear_log();
        press(e0);
        step(3);
        release_btn(eu);
        step(5);
        bus.enable = 1'b0;
        step(1);
        check_val("dis_state", int'(bus.fsm_state), 0);
        check_val("dis_busy", int'(bus.busy), 0);
        step(2);
        bus.enable = 1'b1;
        step(30);
        check_val("dis_no_short", cnt[EV_SHORT], 0);
        check_val("dis_idle_after", int'(bus.fsm_state), 0);

        // Abort: reset pulsed mid-HELD
        press(e0);
        step(45);
        check_val("rstmid_held", int'(bus.fsm_state), 4);
        clear_log();
        #3;
        rst_n            = 1'b0;
        bus.button_state = 1'b0;
        #1;
        check_val("rstmid_state", int'(bus.fsm_state), 0);
        check_val("rstmid_outputs", int'({bus.busy, bus.short_press, bus.long_press, bus.double_click, bus.repeat_pulse}), 0);
        step(2);
        rst_n = 1'b1;
        step(30);
        check_val("rstmid_no_events", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

        check_val("onehot_events", multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
